// File: rtl/alu.sv
// Registered ADD/SUB/AND/OR execute-stage ALU with one cycle of latency.
// Define ALU_FLAGS_EN to add the registered zero/negative/carry/overflow flag outputs.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
`endif
);

    // Handshake: an op is taken at every edge where in_valid=1 (there is no
    // backpressure). out_valid is high for exactly the cycle after that edge.
    // Without a valid op, result and flags keep their last value.

`ifdef ALU_FLAGS_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [WIDTH-1:0] b_eff;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_d, result_q;
    logic             out_valid_d, out_valid_q;

    // SUB is computed as A + ~B + 1, so one adder serves both arithmetic ops.
    always_comb begin
        b_eff = select[0] ? ~B : B;
        sum   = SW'(A) + SW'(b_eff) + SW'(select[0]);
        case (select[1])
            1'b0:    alu_res = sum[WIDTH-1:0];
            1'b1:    alu_res = select[0] ? (A | B) : (A & B);
            default: alu_res = 'x;
        endcase
        result_d    = in_valid ? alu_res : result_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
    logic zero_d, zero_q;
    logic negative_d, negative_q;
    logic carry_d, carry_q;
    logic overflow_d, overflow_q;

    // With b_eff, the "same operand sign" test covers both the ADD rule and
    // the SUB rule (operands of different sign).
    always_comb begin
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        if (in_valid) begin
            zero_d     = (alu_res == '0);
            negative_d = alu_res[WIDTH-1];
            carry_d    = !select[1] && sum[WIDTH];
            overflow_d = !select[1] && (A[WIDTH-1] == b_eff[WIDTH-1])
                         && (sum[WIDTH-1] != A[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign zero     = zero_q;
    assign negative = negative_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: expected {zero,negative,carry,overflow,result}
// values are queued at drive time and popped when out_valid is seen.
module tb_alu;
    localparam int W  = 32;
    localparam int EW = W + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] result;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         zero, negative, carry, overflow;
`endif

    localparam logic [EW-1:0] RST_VAL = {1'b1, 3'b000, {W{1'b0}}};

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp = RST_VAL;
    int            errors = 0;
    int            checks = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .select    (sel),
        .result    (result),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: plain arithmetic plus signed range check.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                            input logic [1:0] is);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        longint       sa, sb, sr, lim;
        sa  = longint'($signed(ia));
        sb  = longint'($signed(ib));
        lim = longint'(1) << (W - 1);
        c = 1'b0;
        v = 1'b0;
        case (is)
            2'b00: begin
                s  = {1'b0, ia} + {1'b0, ib};
                r  = s[W-1:0];
                c  = s[W];
                sr = sa + sb;
                v  = (sr >= lim) || (sr < -lim);
            end
            2'b01: begin
                r  = ia - ib;
                c  = (ia >= ib);
                sr = sa - sb;
                v  = (sr >= lim) || (sr < -lim);
            end
            2'b10:   r = ia & ib;
            default: r = ia | ib;
        endcase
        return {(r == '0), r[W-1], c, v, r};
    endfunction

    function automatic logic [EW-1:0] observed();
`ifdef ALU_FLAGS_EN
        return {zero, negative, carry, overflow, result};
`else
        return {4'b0000, result};
`endif
    endfunction

    function automatic logic [EW-1:0] mask(input logic [EW-1:0] x);
`ifdef ALU_FLAGS_EN
        return x;
`else
        return {4'b0000, x[W-1:0]};
`endif
    endfunction

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (out_valid) begin
            check("valid_has_expect", EW'(exp_q.size() > 0), EW'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", observed(), mask(e));
                last_exp = e;
            end
        end else begin
            check("hold", observed(), mask(last_exp));
        end
    end

    task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] is);
        @(posedge clk);
        #1;
        a = ia;
        b = ib;
        sel = is;
        in_valid = 1'b1;
        exp_q.push_back(model(ia, ib, is));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
            sel = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset holds outputs with no clock edge needed, even with live inputs.
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        sel = 2'b01;
        in_valid = 1'b1;
        #2;
        check("reset_result", observed(), mask(RST_VAL));
        check("reset_valid", EW'(out_valid), EW'(0));
        #10;
        in_valid = 1'b0;
        rst_n = 1'b1;

        drive(10, 5, 2'b00);
        drive(10, 5, 2'b01);
        drive(10, 5, 2'b10);
        drive(10, 5, 2'b11);
        drive(100, 5, 2'b11);
        idle(2);
        drive(5, 10, 2'b01);
        drive(32'hFFFF_FFFF, 1, 2'b00);
        drive(32'h7FFF_FFFF, 1, 2'b00);
        drive(32'h8000_0000, 1, 2'b01);
        drive(32'h1234_5678, 32'h1234_5678, 2'b01);
        drive(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10);
        idle(1);

        // Async reset between edges right after a valid op.
        drive(7, 3, 2'b00);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        last_exp = RST_VAL;
        #1;
        check("async_rst_result", observed(), mask(RST_VAL));
        check("async_rst_valid", EW'(out_valid), EW'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(20, 22, 2'b01);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else drive($urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        idle(3);
        check("drain", EW'(exp_q.size()), EW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
